// File: rtl/fpu_divider.sv
// -----------------------------------------------------------------------------
// fpu_divider
//   IEEE-754 binary32 divider, o_data = i_data_a / i_data_b.
//   Radix-2 restoring core producing one quotient bit per clock, followed by
//   round-to-nearest-even. Fixed latency, one operation in flight.
//   Denormal inputs are flushed to zero. Results never come out subnormal:
//   underflow gives a signed zero.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset
//   i_valid        request strobe, taken only while o_ready=1
//   i_data_a       dividend (binary32)
//   i_data_b       divisor  (binary32)
//   o_ready        core idle, a request can be accepted this cycle
//   o_data         quotient, held until the next o_valid
//   o_valid        one-cycle strobe: o_data / o_div_by_zero are new
//   o_div_by_zero  with o_valid: finite nonzero dividend over a zero divisor
// -----------------------------------------------------------------------------
module fpu_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = 26
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_div_by_zero
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Operand classification (index 0 = dividend, 1 = divisor)
  // ---------------------------------------------------------------------------
  logic [31:0] w_op   [2];
  logic [7:0]  w_exp  [2];
  logic [22:0] w_frac [2];
  logic        w_zero [2];
  logic        w_inf  [2];
  logic        w_nan  [2];

  assign w_op[0] = i_data_a;
  assign w_op[1] = i_data_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_classify
    assign w_exp[gi]  = w_op[gi][30:23];
    assign w_frac[gi] = w_op[gi][22:0];
    // A zero exponent field is treated as zero whatever the fraction holds,
    // which is what flushes denormal inputs.
    assign w_zero[gi] = (w_exp[gi] == 8'h00);
    assign w_inf[gi]  = (w_exp[gi] == 8'hFF) && (w_frac[gi] == 23'd0);
    assign w_nan[gi]  = (w_exp[gi] == 8'hFF) && (w_frac[gi] != 23'd0);
  end

  logic w_sign;
  assign w_sign = i_data_a[31] ^ i_data_b[31];

  // Special-case result, decided at accept and carried through the pipeline
  // so specials emerge with the same latency as ordinary quotients.
  logic        w_special;
  logic        w_special_dbz;
  logic [31:0] w_special_data;

  always_comb begin
    w_special      = 1'b1;
    w_special_dbz  = 1'b0;
    w_special_data = 32'h7FC0_0000;
    if (w_nan[0] || w_nan[1] || (w_zero[0] && w_zero[1]) || (w_inf[0] && w_inf[1])) begin
      w_special_data = 32'h7FC0_0000;
    end else if (w_inf[0]) begin
      w_special_data = {w_sign, 8'hFF, 23'd0};
    end else if (w_zero[1]) begin
      w_special_data = {w_sign, 8'hFF, 23'd0};
      w_special_dbz  = 1'b1;
    end else if (w_zero[0] || w_inf[1]) begin
      w_special_data = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Normal-path setup: pre-normalise so the quotient lands in [1,2)
  // ---------------------------------------------------------------------------
  logic [23:0]       w_ma;
  logic [23:0]       w_mb;
  logic              w_a_lt_b;
  logic signed [9:0] w_exp_init;
  logic [25:0]       w_rem_init;

  assign w_ma     = {1'b1, w_frac[0]};
  assign w_mb     = {1'b1, w_frac[1]};
  assign w_a_lt_b = (w_ma < w_mb);

  assign w_exp_init = $signed({2'b00, w_exp[0]}) - $signed({2'b00, w_exp[1]})
                    + 10'sd127 - (w_a_lt_b ? 10'sd1 : 10'sd0);
  assign w_rem_init = w_a_lt_b ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [25:0]       r_rem;
  logic [23:0]       r_mb;
  logic [25:0]       r_q;
  logic signed [9:0] r_exp;
  logic              r_sign;
  logic              r_special;
  logic              r_special_dbz;
  logic [31:0]       r_special_data;
  logic [23:0]       r_mant;

  // One restoring step. The partial remainder is always below 2*mb, so a
  // single compare/subtract yields each quotient bit.
  logic        w_ge;
  logic [25:0] w_rem_sub;

  assign w_ge      = (r_rem >= {2'b00, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

  // Round-to-nearest-even on q = {mant[23:0], guard, round}; whatever is left
  // in the remainder acts as the sticky bit.
  logic        w_guard;
  logic        w_round;
  logic        w_sticky;
  logic        w_inc;
  logic [24:0] w_mant_sum;

  assign w_guard    = r_q[1];
  assign w_round    = r_q[0];
  assign w_sticky   = (r_rem != 26'd0);
  assign w_inc      = w_guard & (w_round | w_sticky | r_q[2]);
  assign w_mant_sum = {1'b0, r_q[25:2]} + {24'd0, w_inc};

  // Final packing with overflow to infinity and underflow flushed to zero.
  logic [31:0] w_result;

  always_comb begin
    w_result = {r_sign, r_exp[7:0], r_mant[22:0]};
    if (r_special) begin
      w_result = r_special_data;
    end else if (r_exp >= 10'sd255) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (r_exp <= 10'sd0) begin
      w_result = {r_sign, 31'd0};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_mb           <= '0;
      r_q            <= '0;
      r_exp          <= '0;
      r_sign         <= 1'b0;
      r_special      <= 1'b0;
      r_special_dbz  <= 1'b0;
      r_special_data <= '0;
      r_mant         <= '0;
      o_ready        <= 1'b1;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_div_by_zero  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            r_state        <= S_DIVIDE;
            r_cnt          <= '0;
            r_rem          <= w_rem_init;
            r_mb           <= w_mb;
            r_q            <= '0;
            r_exp          <= w_exp_init;
            r_sign         <= w_sign;
            r_special      <= w_special;
            r_special_dbz  <= w_special_dbz;
            r_special_data <= w_special_data;
            o_ready        <= 1'b0;
            o_div_by_zero  <= 1'b0;
          end
        end

        S_DIVIDE: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(ITER - 1)) begin
            r_state <= S_ROUND;
          end
        end

        S_ROUND: begin
          // A carry out of the 24-bit significand means it rounded up to 2.0.
          if (w_mant_sum[24]) begin
            r_mant <= 24'h80_0000;
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= w_mant_sum[23:0];
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          o_data        <= w_result;
          o_div_by_zero <= r_special & r_special_dbz;
          o_valid       <= 1'b1;
          o_ready       <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divider.sv
// -----------------------------------------------------------------------------
// tb_fpu_divider
//   Directed and random stimulus for fpu_divider. A reference model derives
//   each quotient from exact integer arithmetic on the operand values, and a
//   per-cycle checker predicts o_ready / o_valid / o_data / o_div_by_zero from
//   the accept time plus the fixed 28-edge latency.
// -----------------------------------------------------------------------------
module tb_fpu_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_dbz;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  fpu_divider #(
    .DATA_WIDTH (32),
    .ITER       (26)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (in_valid),
    .i_data_a      (in_a),
    .i_data_b      (in_b),
    .o_ready       (out_ready),
    .o_data        (out_data),
    .o_valid       (out_valid),
    .o_div_by_zero (out_dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) n_edges <= n_edges + 1;

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, exp, n_edges);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: returns {div_by_zero, quotient}
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sg, za, zb, ia, ib, na, nb;
    longint      n, d, q, r;
    int          e;
    ea = a[30:23]; fa = a[22:0];
    eb = b[30:23]; fb = b[22:0];
    sg = a[31] ^ b[31];
    za = (ea == 0);                ia = (ea == 255) && (fa == 0); na = (ea == 255) && (fa != 0);
    zb = (eb == 0);                ib = (eb == 255) && (fb == 0); nb = (eb == 255) && (fb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {1'b0, 32'h7FC0_0000};
    if (ia) return {1'b0, sg, 8'hFF, 23'd0};
    if (zb) return {1'b1, sg, 8'hFF, 23'd0};
    if (za || ib) return {1'b0, sg, 31'd0};
    // value = (n/d) * 2^(e-127), normalised so n/d lies in [1,2)
    n = longint'({1'b1, fa});
    d = longint'({1'b1, fb});
    e = int'(ea) - int'(eb) + 127;
    if (n < d) begin
      n = n * 2;
      e = e - 1;
    end
    q = (n * (64'sd1 << 23)) / d;
    r = (n * (64'sd1 << 23)) % d;
    if ((2 * r > d) || ((2 * r == d) && (q % 2 == 1))) q = q + 1;
    if (q == (64'sd1 << 24)) begin
      q = 64'sd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {1'b0, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, sg, 31'd0};
    return {1'b0, sg, 8'(e), q[22:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle checker: outputs sampled at the falling edge, then the effect
  // of the coming rising edge is predicted from the inputs held there.
  // ---------------------------------------------------------------------------
  logic        armed       = 1'b0;
  logic        exp_ready   = 1'b1;
  logic        exp_valid   = 1'b0;
  logic [31:0] exp_data    = 32'd0;
  logic        exp_dbz     = 1'b0;
  logic [32:0] pending     = 33'd0;
  int          accept_edge = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("o_ready", {31'd0, out_ready}, {31'd0, exp_ready});
        chk("o_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("o_data", out_data, exp_data);
        chk("o_div_by_zero", {31'd0, out_dbz}, {31'd0, exp_dbz});
      end
      if (rst) begin
        armed       = 1'b1;
        exp_ready   = 1'b1;
        exp_valid   = 1'b0;
        exp_data    = 32'd0;
        exp_dbz     = 1'b0;
        accept_edge = -1;
      end else if (armed) begin
        exp_valid = 1'b0;
        if (accept_edge >= 0 && n_edges + 1 == accept_edge + 28) begin
          exp_valid   = 1'b1;
          exp_ready   = 1'b1;
          exp_dbz     = pending[32];
          exp_data    = pending[31:0];
          accept_edge = -1;
        end else if (exp_ready && in_valid) begin
          accept_edge = n_edges + 1;
          pending     = ref_div(in_a, in_b);
          exp_ready   = 1'b0;
          exp_dbz     = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: o_ready stayed 0, required 1 within 80 cycles");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input bit use_lit,
                             input logic [31:0] lit, input logic lit_dbz);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: no o_valid, required one within 40 cycles", name);
    end else begin
      $display("op %s: a=%08h b=%08h -> %08h dbz=%0d", name, in_a, in_b, out_data, out_dbz);
      if (use_lit) begin
        chk({name, "_data"}, out_data, lit);
        chk({name, "_dbz"}, {31'd0, out_dbz}, {31'd0, lit_dbz});
      end
    end
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input bit use_lit, input logic [31:0] lit, input logic lit_dbz);
    issue(a, b);
    wait_result(name, use_lit, lit, lit_dbz);
  endtask

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors with hand-derived results
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
  } vec_t;

  vec_t vecs[12] = '{
    '{"six_div_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0},
    '{"one_div_three",32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0},
    '{"three_div_3",  32'h4040_0000, 32'h4040_0000, 32'h3F80_0000, 1'b0},
    '{"neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1},
    '{"zero_div_zero",32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0},
    '{"overflow",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0},
    '{"underflow",    32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 1'b0},
    '{"inf_div_two",  32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0},
    '{"two_div_ninf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0},
    '{"nan_div_one",  32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0},
    '{"denorm_div_1", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0},
    '{"one_div_denorm",32'h3F80_0000,32'h0000_0005, 32'h7F80_0000, 1'b1}
  };

  initial begin
    bit          seen;
    logic [32:0] m;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = 32'd0;
    in_b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, out_ready}, 32'd1);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    rst = 1'b0;

    // Pin the model on the hand-computed vectors, then run them on the DUT.
    foreach (vecs[i]) begin
      m = ref_div(vecs[i].a, vecs[i].b);
      chk({"model_", vecs[i].name}, m[31:0], vecs[i].q);
    end
    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].dbz);

    // A request arriving while busy is dropped; the first result stands.
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_a     = 32'h3F80_0000;
    in_b     = 32'h4040_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 32'h40C0_0000;
    in_b     = 32'h4000_0000;
    wait_result("busy_drop", 1'b1, 32'h4040_0000, 1'b0);

    // Reset mid-operation aborts it; a request held during reset is ignored.
    issue(32'h3F80_0000, 32'h4040_0000);
    repeat (9) begin @(posedge clk); #1; end
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("abort_ready", {31'd0, out_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    do_op("after_reset", 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h3F80_0000, 1'b0);

    // Request held high continuously: accepts every 29 cycles.
    in_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      in_a = rand_normal();
      in_b = rand_normal();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_ready();

    // Random normal operand pairs, checked by the per-cycle model.
    for (int i = 0; i < 1200; i++)
      do_op("random", rand_normal(), rand_normal(), 1'b0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
